// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
//
// Sequencer for a 16:1 bit multiplexer. It drives the mux select lines and
// samples the mux output, either once for a single channel or across all 16
// channels to rebuild a 16-bit word.
//
// Handshake: start is a request pulse taken only while the FSM is idle
// (busy=0, done=0). After acceptance busy stays high until the operation
// finishes. A finished operation raises done for exactly one cycle, and from
// the following cycle data_valid=1 with data_out holding the result. Both
// remain until the next accepted start or reset. An abort while busy ends
// the operation with no done pulse and a cleared result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request pulse, accepted only in IDLE
//   mode       0 = single-channel read, 1 = full scan (latched on accept)
//   chan_sel   channel for a single read (latched on accept)
//   abort      cancels an operation in SETTLE or SAMPLE
//   mux_in     output bit of the 16:1 mux (synchronous to clk)
//   sel_out    mux select S[3:0]
//   busy       high in SETTLE and SAMPLE
//   done       one-cycle completion pulse
//   data_out   result word
//   data_valid data_out holds a completed result
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [3:0]  chan_sel,
  input  logic        abort,
  input  logic        mux_in,
  output logic [3:0]  sel_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] data_out,
  output logic        data_valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        mode_q, mode_n;
  logic [3:0]  sel_n;
  logic [15:0] data_n;
  logic        valid_n;

  // Next-state and datapath logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_q;
    sel_n   = sel_out;
    data_n  = data_out;
    valid_n = data_valid;
    busy    = 1'b0;
    done    = 1'b0;

    case (state)
      S_IDLE: begin
        // abort is ignored here, so start wins when both are high.
        if (start) begin
          mode_n  = mode;
          sel_n   = mode ? 4'd0 : chan_sel;
          data_n  = '0;
          valid_n = 1'b0;
          cnt_n   = '0;
          state_n = S_SETTLE;
        end
      end

      S_SETTLE: begin
        busy = 1'b1;
        if (abort) begin
          data_n  = '0;
          valid_n = 1'b0;
          state_n = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = S_SAMPLE;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end

      S_SAMPLE: begin
        busy = 1'b1;
        // Abort takes priority over the capture of mux_in.
        if (abort) begin
          data_n  = '0;
          valid_n = 1'b0;
          state_n = S_IDLE;
        end else if (!mode_q) begin
          data_n  = {15'b0, mux_in};
          state_n = S_DONE;
        end else begin
          data_n[sel_out] = mux_in;
          if (sel_out == 4'd15) begin
            // The scan ends at channel 15; sel_out is not wrapped back to 0.
            state_n = S_DONE;
          end else begin
            sel_n   = sel_out + 4'd1;
            cnt_n   = '0;
            state_n = S_SETTLE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        valid_n = 1'b1;
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mode_q     <= 1'b0;
      sel_out    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      mode_q     <= mode_n;
      sel_out    <= sel_n;
      data_out   <= data_n;
      data_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  // Instance a: SETTLE_CYC = 1
  logic        start, mode, abort, mux_in;
  logic [3:0]  chan_sel, sel_out;
  logic        busy, done, data_valid;
  logic [15:0] data_out;

  // Instance b: SETTLE_CYC = 3
  logic        start_b, mode_b, abort_b, mux_in_b;
  logic [3:0]  chan_sel_b, sel_out_b;
  logic        busy_b, done_b, data_valid_b;
  logic [15:0] data_out_b;

  // Mux model: the 16 mux data inputs I[15:0].
  logic [15:0] mux_word;
  assign mux_in   = mux_word[sel_out];
  assign mux_in_b = mux_word[sel_out_b];

  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl #(.SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .chan_sel(chan_sel),
    .abort(abort), .mux_in(mux_in), .sel_out(sel_out), .busy(busy),
    .done(done), .data_out(data_out), .data_valid(data_valid)
  );

  mux_scan_ctrl #(.SETTLE_CYC(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .chan_sel(chan_sel_b),
    .abort(abort_b), .mux_in(mux_in_b), .sel_out(sel_out_b), .busy(busy_b),
    .done(done_b), .data_out(data_out_b), .data_valid(data_valid_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_done(input bit b);
    return b ? done_b : done;
  endfunction
  function automatic logic [3:0] o_sel(input bit b);
    return b ? sel_out_b : sel_out;
  endfunction
  function automatic logic [15:0] o_data(input bit b);
    return b ? data_out_b : data_out;
  endfunction
  function automatic logic o_valid(input bit b);
    return b ? data_valid_b : data_valid;
  endfunction

  // Full operation on instance b (0 = a, 1 = b): checks the select sequence,
  // the completion cycle (start sampled at edge 0), the result and data_valid.
  task automatic run_op(input bit b, input bit m, input logic [3:0] ch, input int exp_cyc);
    int  cyc;
    int  sel_bad;
    int  settle;
    bit  seen;
    logic [3:0] es;
    settle = b ? 3 : 1;
    exp_q.push_back(m ? mux_word : {15'b0, mux_word[ch]});
    if (b) begin start_b = 1'b1; mode_b = m; chan_sel_b = ch; end
    else   begin start   = 1'b1; mode   = m; chan_sel   = ch; end
    tick();
    start = 1'b0; start_b = 1'b0;
    cyc = 1; sel_bad = 0; seen = 0;
    while (!seen && cyc < 400) begin
      if (o_done(b)) seen = 1;
      else begin
        es = m ? 4'((cyc - 1) / (settle + 1)) : ch;
        if (o_sel(b) !== es) sel_bad++;
        tick();
        cyc++;
      end
    end
    check("done_seen", 32'(seen), 1);
    check("done_cycle", cyc, exp_cyc);
    check("sel_sequence", sel_bad, 0);
    check("result", o_data(b), exp_q.pop_front());
    tick();
    check("valid_after", 32'(o_valid(b)), 1);
    check("done_one_cycle", 32'(o_done(b)), 0);
  endtask

  // Waits (bounded) for done on instance a; returns the cycle it was seen.
  task automatic wait_done(input int cyc_in, output int cyc_out, output bit seen);
    cyc_out = cyc_in;
    seen = 0;
    while (!seen && cyc_out < 400) begin
      if (done) seen = 1;
      else begin tick(); cyc_out++; end
    end
  endtask

  initial begin
    int  cyc;
    bit  seen;
    bit  poked;
    int  done_cnt;

    rst = 1'b1;
    start = 0; mode = 0; chan_sel = 0; abort = 0;
    start_b = 0; mode_b = 0; chan_sel_b = 0; abort_b = 0;
    mux_word = 16'h0000;
    tick(); tick();
    rst = 1'b0;

    // 1. Reset values after idling.
    repeat (5) tick();
    check("rst_sel", sel_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", data_out, 16'h0000);
    check("rst_valid", data_valid, 0);
    check("rst_b_valid", data_valid_b, 0);

    // 2. Single read of channel 6.
    mux_word = 16'hA5C3;
    run_op(0, 0, 4'd6, 3);

    // 3. Full scans with SETTLE_CYC = 1 and 3.
    run_op(0, 1, 4'd0, 33);
    run_op(1, 1, 4'd0, 65);
    mux_word = 16'h3C96;
    run_op(0, 1, 4'd7, 33);

    // 4a. A start pulse during a scan is ignored.
    mux_word = 16'hA5C3;
    exp_q.push_back(mux_word);
    start = 1; mode = 1; chan_sel = 0;
    tick();
    start = 0;
    cyc = 1; poked = 0; seen = 0;
    while (!seen && cyc < 400) begin
      if (done) seen = 1;
      else begin
        start = 1'b0;
        if (!poked && sel_out == 4'd5) begin
          start = 1'b1; mode = 0; chan_sel = 4'd3; poked = 1;
        end
        tick();
        cyc++;
      end
    end
    start = 0;
    check("poke_done_cycle", cyc, 33);
    check("poke_result", data_out, exp_q.pop_front());
    tick();

    // 4b. Abort at sel_out = 9: no done, result cleared, select held.
    start = 1; mode = 1;
    tick();
    start = 0;
    done_cnt = 0; cyc = 0;
    while (sel_out != 4'd9 && cyc < 400) begin
      if (done) done_cnt++;
      tick();
      cyc++;
    end
    check("abort_reach_sel9", sel_out, 4'd9);
    abort = 1;
    tick();
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_valid", data_valid, 0);
    check("abort_data", data_out, 16'h0000);
    check("abort_sel_hold", sel_out, 4'd9);
    repeat (4) begin
      if (done) done_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 0);

    // 5. Reset in the middle of a scan, then a single read of channel 15.
    start = 1; mode = 1;
    tick();
    start = 0;
    cyc = 0;
    while (sel_out != 4'd12 && cyc < 400) begin tick(); cyc++; end
    rst = 1;
    tick();
    rst = 0;
    check("mrst_sel", sel_out, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_data", data_out, 16'h0000);
    check("mrst_valid", data_valid, 0);
    mux_word = 16'h8000;
    run_op(0, 0, 4'd15, 3);

    // 6. start held high: re-accepted in the cycle after DONE.
    mux_word = 16'hA5C3;
    exp_q.push_back({15'b0, mux_word[0]});
    start = 1; mode = 0; chan_sel = 4'd0;
    tick();
    wait_done(1, cyc, seen);
    check("b2b_first_cycle", cyc, 3);
    check("b2b_first_result", data_out, exp_q.pop_front());
    chan_sel = 4'd2;
    exp_q.push_back({15'b0, mux_word[2]});
    tick();
    check("b2b_gap_busy", busy, 0);
    check("b2b_gap_valid", data_valid, 1);
    tick();
    check("b2b_accept_busy", busy, 1);
    check("b2b_accept_valid", data_valid, 0);
    check("b2b_accept_sel", sel_out, 4'd2);
    wait_done(5, cyc, seen);
    check("b2b_second_cycle", cyc, 7);
    check("b2b_second_result", data_out, exp_q.pop_front());
    start = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
